// File: rtl/df_mac_pkg.sv
// Shared widths, Q4.12 constants and FSM encodings for the data-feed MAC.
package df_mac_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned FRAC_BITS  = 12;
  localparam int unsigned ACC_WIDTH  = 36;

  typedef logic [DATA_WIDTH-1:0] word_data_bus_t;
  typedef logic [2:0]            word_addr_bus_t;

  localparam logic [DATA_WIDTH-1:0] ONE_Q   = 16'h1000;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = 16'h8000;

  localparam logic [1:0] DF_IDLE  = 2'd0;
  localparam logic [1:0] DF_RUN   = 2'd1;
  localparam logic [1:0] DF_DRAIN = 2'd2;
  localparam logic [1:0] DF_OUT   = 2'd3;

endpackage

// File: rtl/df_mul.sv
// Registered signed multiplier: one product per enabled cycle, with a matching valid flag.
module df_mul #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic [DATA_W-1:0]            a_i,
  input  logic [DATA_W-1:0]            b_i,
  output logic signed [2*DATA_W-1:0]   p_o,
  output logic                         valid_o
);

  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic                       valid_q, valid_d;

  // Next product: capture only when enabled so the last value stays visible.
  always_comb begin
    prod_d  = prod_q;
    valid_d = en_i;
    if (en_i) begin
      prod_d = $signed(a_i) * $signed(b_i);
    end
  end

  // Product and valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign p_o     = prod_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/df_mac.sv
// Neuron accumulate stage: sequences the 8:1 feed mux, multiplies each operand by a stored
// weight, accumulates, then rounds / saturates / optionally ReLUs into a valid/ready output.
module df_mac
  import df_mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_WIDTH,
  parameter int unsigned FRAC   = FRAC_BITS,
  parameter int unsigned ACC_W  = ACC_WIDTH,
  parameter int unsigned ACT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [2:0]        sel,
  input  logic [DATA_W-1:0] data_i,
  input  logic              w_we,
  input  logic [2:0]        w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAX_R    = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MIN_R    = -(ACC_W'(1) << (DATA_W - 1));
  localparam logic [DATA_W-1:0]       SAT_HI   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       SAT_LO   = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]                   state_q, state_d;
  logic [2:0]                   sel_q, sel_d;
  logic                         drain_q, drain_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [DATA_W-1:0]            out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic [7:0][DATA_W-1:0]       w_q, w_d;

  logic                         mul_en;
  logic signed [2*DATA_W-1:0]   prod;
  logic                         prod_valid;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      rnd_sum;
  logic signed [ACC_W-1:0]      rnd;
  logic [DATA_W-1:0]            sat_res;
  logic [DATA_W-1:0]            act_res;
  logic                         start_acc;

  assign start_acc = (state_q == DF_IDLE) && start;
  assign mul_en    = (state_q == DF_RUN);

  df_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (reset),
    .en_i    (mul_en),
    .a_i     (data_i),
    .b_i     (w_q[sel_q]),
    .p_o     (prod),
    .valid_o (prod_valid)
  );

  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Weight file: writable only outside an evaluation so the set is frozen while it runs.
  always_comb begin
    w_d = w_q;
    if (w_we && ((state_q == DF_IDLE) || (state_q == DF_OUT))) begin
      w_d[w_addr] = w_data;
    end
  end

  // Accumulator: cleared on start acceptance, then sums each product as it leaves stage 1.
  always_comb begin
    acc_d = acc_q;
    if (start_acc) begin
      acc_d = '0;
    end else if (prod_valid) begin
      acc_d = acc_q + prod_ext;
    end
  end

  // Round half up, saturate to the output width, then optional ReLU.
  always_comb begin
    rnd_sum = acc_q + HALF_LSB;
    rnd     = rnd_sum >>> FRAC;
    if (rnd > MAX_R) begin
      sat_res = SAT_HI;
    end else if (rnd < MIN_R) begin
      sat_res = SAT_LO;
    end else begin
      sat_res = rnd[DATA_W-1:0];
    end
    act_res = sat_res;
    if ((ACT != 0) && sat_res[DATA_W-1]) begin
      act_res = '0;
    end
  end

  // Sequencer FSM: IDLE -> RUN (8 operands) -> DRAIN (2 cycles) -> OUT (hold until ready).
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    drain_d     = drain_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      DF_IDLE: begin
        if (start) begin
          state_d = DF_RUN;
          sel_d   = 3'd0;
        end
      end
      DF_RUN: begin
        if (sel_q == 3'd7) begin
          state_d = DF_DRAIN;
          sel_d   = 3'd0;
          drain_d = 1'b0;
        end else begin
          sel_d = sel_q + 3'd1;
        end
      end
      DF_DRAIN: begin
        // Second drain cycle: the last product has been accumulated into acc_q.
        if (drain_q) begin
          state_d     = DF_OUT;
          drain_d     = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = act_res;
        end else begin
          drain_d = 1'b1;
        end
      end
      DF_OUT: begin
        if (out_ready) begin
          state_d     = DF_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = DF_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= DF_IDLE;
      sel_q       <= 3'd0;
      drain_q     <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      w_q         <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      drain_q     <= drain_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      w_q         <= w_d;
    end
  end

  assign busy      = (state_q != DF_IDLE);
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_df_mac.sv
// Directed bench for df_mac: a linear (ACT=0) and a ReLU (ACT=1) instance run in lock-step
// against a modelled 8:1 feed mux whose slot 7 is the constant 1.0.
module tb_df_mac;
  import df_mac_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        w_we;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic        out_ready;

  logic [2:0]  sel0, sel1;
  logic [15:0] data0, data1;
  logic [15:0] out0, out1;
  logic        valid0, valid1;
  logic        busy0, busy1;

  logic [15:0] dmem [8];

  int n_vec = 0;
  int n_err = 0;

  assign data0 = dmem[sel0];
  assign data1 = dmem[sel1];

  always #5 clk = ~clk;

  df_mac #(.ACT(0)) dut_lin (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy0),
    .sel       (sel0),
    .data_i    (data0),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_data  (out0),
    .out_valid (valid0),
    .out_ready (out_ready)
  );

  df_mac #(.ACT(1)) dut_relu (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy1),
    .sel       (sel1),
    .data_i    (data1),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_data  (out1),
    .out_valid (valid1),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    w_we   = 1'b1;
    w_addr = a;
    w_data = d;
    @(posedge clk); #1;
    w_we   = 1'b0;
  endtask

  // One evaluation: checks latency, both results and (optionally) the sel walk.
  task automatic run_eval(input string tag, input logic [15:0] exp_lin,
                          input logic [15:0] exp_relu, input bit chk_sel);
    int lat;
    lat = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("%s_busy", tag), busy0, 1);
    if (chk_sel) check($sformatf("%s_sel0", tag), sel0, 0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (chk_sel && k <= 8) check($sformatf("%s_sel%0d", tag, k), sel0, (k == 8) ? 0 : k);
      if (valid0) begin
        lat = k;
        break;
      end
    end
    check($sformatf("%s_latency", tag), lat, 10);
    check($sformatf("%s_lin", tag), out0, exp_lin);
    check($sformatf("%s_relu", tag), out1, exp_relu);
    check($sformatf("%s_relu_valid", tag), valid1, 1);
    if (out_ready) begin
      @(posedge clk); #1;
      check($sformatf("%s_valid_drop", tag), valid0, 0);
      check($sformatf("%s_idle", tag), busy0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    reset     = 1'b1;
    start     = 1'b0;
    w_we      = 1'b0;
    w_addr    = 3'd0;
    w_data    = 16'h0000;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) dmem[i] = 16'h0000;
    dmem[7] = ONE_Q;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out0, 16'h0000);
    check("rst_valid", valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_sel", sel0, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic: 2.0 * 0.5 = 1.0; other weights zero so the other operands vanish
    wr(3'd0, 16'h2000);
    dmem[0] = 16'h0800;
    for (int i = 1; i < 7; i++) dmem[i] = 16'h1234;
    run_eval("basic", 16'h1000, 16'h1000, 1'b1);

    // Positive saturation: 7 x 1.0 + bias 1.0 = 8.0
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000);
    for (int i = 0; i < 7; i++) dmem[i] = 16'h1000;
    run_eval("sat_pos", 16'h7FFF, 16'h7FFF, 1'b0);

    // Negative edge: 7 x -1.0 + bias -1.0 = -8.0 exactly
    for (int i = 0; i < 7; i++) dmem[i] = 16'hF000;
    wr(3'd7, 16'hF000);
    run_eval("sat_neg", 16'h8000, 16'h0000, 1'b0);

    // Bias only
    for (int i = 0; i < 7; i++) wr(3'(i), 16'h0000);
    run_eval("bias", 16'hF000, 16'h0000, 1'b0);

    // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds up to zero
    wr(3'd0, 16'h0800);
    wr(3'd7, 16'h0000);
    dmem[0] = 16'h0001;
    run_eval("rnd_pos", 16'h0001, 16'h0001, 1'b0);
    dmem[0] = 16'hFFFF;
    run_eval("rnd_neg", 16'h0000, 16'h0000, 1'b0);

    // Backpressure, ignored start in OUT, dropped write during RUN
    wr(3'd0, 16'h2000);
    dmem[0] = 16'h0800;
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    w_we   = 1'b1;
    w_addr = 3'd0;
    w_data = 16'h7FFF;
    @(posedge clk); #1;
    w_we = 1'b0;
    lat = 0;
    for (int k = 3; k <= 20; k++) begin
      @(posedge clk); #1;
      if (valid0) begin
        lat = k;
        break;
      end
    end
    check("bp_latency", lat, 10);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_valid%0d", c), valid0, 1);
      check($sformatf("bp_hold_data%0d", c), out0, 16'h1000);
      start = (c == 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("bp_still_busy", busy0, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake", valid0, 0);
    check("bp_idle", busy0, 0);
    @(posedge clk); #1;
    check("bp_start_ignored", busy0, 0);
    run_eval("bp_old_w0", 16'h1000, 16'h1000, 1'b0);

    // Reset mid-RUN: outputs clear at once, weights reset to zero
    for (int i = 0; i < 7; i++) dmem[i] = 16'h1000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sel0 == 3'd4) break;
      @(posedge clk); #1;
    end
    check("mid_sel4", sel0, 4);
    reset = 1'b1;
    #1;
    check("mid_rst_out", out0, 16'h0000);
    check("mid_rst_valid", valid0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_sel", sel0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_eval("post_rst", 16'h0000, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/df_mac.md
Name: df_mac

Overview:
- Neuron accumulate stage directly downstream of the 8:1 data-feed mux.
- Drives the mux `sel` from an internal sequencer and consumes the mux output `data_i` (Q4.12 signed) each cycle.
- Multiplies each operand by a locally stored weight and accumulates. Slot 7 is the constant 1.0, so weight 7 acts as bias.
- Rounds, saturates, optionally applies ReLU, and presents one neuron result per `start` through a valid/ready output.

Parameters:
- DATA_W, 16, operand/weight/result width (`DATA_WIDTH`, Q4.12).
- FRAC, 12, fractional bits.
- ACC_W, 36, accumulator width; 8 products cannot overflow it.
- ACT, 0, activation: 0 = linear, 1 = ReLU.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one neuron evaluation; sampled only in IDLE.
- busy  out  1  high in RUN/DRAIN/OUT.
- sel  out  3  mux select (`WordAddrBus`), to the data-feed mux.
- data_i  in  16  selected operand from the mux, valid in the same cycle as `sel`.
- w_we  in  1  weight write enable.
- w_addr  in  3  weight index 0..7 (7 = bias).
- w_data  in  16  weight value, Q4.12 signed.
- out_data  out  16  neuron result, Q4.12 signed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async, active-high): state=IDLE, sel=0, out_data=0, out_valid=0, busy=0, accumulator=0, pipeline valids=0, all 8 weights=0.
- FSM states: IDLE, RUN, DRAIN, OUT.
- IDLE
  - start=1 at edge E0 → RUN; clear accumulator; sel=0.
- RUN
  - sel increments once per cycle (0..7); after E7 sel=7.
  - At E8 → DRAIN; sel returns to 0.
  - start is ignored.
- Datapath pipeline
  - Stage 1: product reg = signed(data_i) * signed(w[sel]), 32-bit Q8.24, captured at E1..E8.
  - Stage 2: acc += sign-extend(product), at E2..E9.
- DRAIN
  - 2 cycles (E8, E9) to flush the pipeline.
  - At E10: out_data = sat16(ACT(round(acc))), out_valid=1, state=OUT.
  - Latency is fixed at 10 cycles from start acceptance to out_valid.
- Rounding: r = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift (round half up).
- Saturation: r > 32767 → 0x7FFF; r < -32768 → 0x8000.
- ReLU (ACT=1): negative saturated result → 0x0000. Order is round → saturate → ReLU.
- OUT
  - out_valid and out_data held stable until out_ready=1.
  - On the handshake edge: out_valid=0, state=IDLE.
  - out_ready=1 in the same cycle out_valid rises is a legal single-cycle transfer.
  - start asserted while in OUT is ignored. start is only sampled in IDLE, so back-to-back issue costs one IDLE cycle.
- Weight writes
  - Applied on the clock edge when in IDLE or OUT.
  - Silently dropped in RUN/DRAIN; the weight set is frozen during an evaluation.
  - A write and start in the same IDLE cycle: the write takes effect and is used by that evaluation.
- sel is registered; the mux is combinational, so data_i is valid in the same cycle.
- Reset mid-operation: immediate return to reset values; any partial accumulation is discarded; no out_valid.
- busy = (state != IDLE).

Decomposition:
- Shared defines (stddef.h):
  - `DATA_WIDTH`, `WordDataBus`, `WordAddrBus` (existing).
  - Add `FRAC_BITS` 12, `ONE_Q` 16'h1000, `ACC_WIDTH` 36, `SAT_MAX` 16'h7FFF, `SAT_MIN` 16'h8000.
  - Add FSM state encodings `DF_IDLE`/`DF_RUN`/`DF_DRAIN`/`DF_OUT`.
- Sub-module df_mul: registered 16×16 signed multiplier (stage 1), reused by later multi-neuron arrays.
- Sequencer, accumulator, round/sat/ReLU and the weight regfile remain in df_mac.

Test Plan:
- Basic:
  - Stimulus: w0=0x2000, w1..w7=0; data_in_0=0x0800; start.
  - Required: out_valid exactly 10 cycles after start accepted; out_data=0x1000; sel sequence 0,1,..,7.
- Saturation:
  - Stimulus: all weights 0x1000; data_in_0..6=0x1000 (sum 8.0); start.
  - Required: out_data=0x7FFF. Repeat with all data 0xF000 (-1.0) and w7=0xF000 → 0x8000.
- Bias/ReLU:
  - Stimulus: w0..6=0, w7=0xF000.
  - Required: ACT=0 → 0xF000; ACT=1 → 0x0000.
- Rounding:
  - Stimulus: w0=0x0800, data_in_0=0x0001, rest 0.
  - Required: out_data=0x0001. With data_in_0=0xFFFF → 0x0000 (round half up).
- Backpressure and frozen weights:
  - Stimulus: hold out_ready=0 for 5 cycles; pulse start; write w0 during RUN.
  - Required: out_data stable, second start ignored, w0 write dropped; after out_ready=1, next start uses the old w0.
- Reset mid-RUN:
  - Stimulus: assert reset at sel=4.
  - Required: outputs go to 0 immediately; after release, the next start gives a correct result with all weights=0, i.e. out_data=0x0000.
